load_store_unit: RTL
====================

# load_store_unit

Data-memory stage of the single-cycle RV32 core. It sits directly downstream of the datapath: it consumes the ALU result as the effective address and rs2 as store data, and returns sign/zero-extended load data for the register write-back mux. It owns a synchronous byte-enable data RAM with one-cycle read latency. It stalls the core for one extra cycle on every load and flags misaligned or illegal accesses.

## Interface
Parameters:
- DEPTH_WORDS, 256: data RAM depth in 32-bit words; power of two, at least 4.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- mem_read  in  1  current instruction is a load.
- mem_write  in  1  current instruction is a store.
- funct3  in  3  instruction[14:12]; selects access size and signedness.
- addr  in  32  effective address (ALU result).
- store_data  in  32  rs2 value.
- load_data  out  32  extended load result, valid in the RESP cycle, 0 otherwise.
- stall  out  1  combinational; holds PC and suppresses register write-back while high.
- fault  out  1  combinational; pulses in the cycle an illegal or misaligned access is presented.
- fault_sticky  out  1  registered; set by any fault, cleared only by reset.

## Operation
- Word index is addr[AW+1:2], where AW = log2(DEPTH_WORDS). Upper address bits are ignored, so addresses wrap modulo 4*DEPTH_WORDS bytes.
- Legal load funct3 values: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Legal store funct3 values: 000 SB, 001 SH, 010 SW.
- Fault conditions:
  - illegal funct3;
  - halfword access with addr[0]=1;
  - word access with addr[1:0]≠00;
  - mem_read and mem_write both high.
- A faulting access performs no RAM read or write, raises no stall, and leaves load_data at 0.
- Stores:
  - Byte enables are 0001<<addr[1:0] for SB and 0011<<addr[1:0] for SH; SW writes all four lanes.
  - Store data is replicated across lanes: SB byte ×4, SH half ×2.
  - The write lands at the clock edge ending the store cycle. No stall.
- Loads use a two-state FSM:
  - IDLE: if mem_read is high and there is no fault, stall=1. The RAM read is issued and addr[1:0] and funct3 are latched. Next state is RESP.
  - RESP: stall=0. The latched lane is selected and extended (LB/LH sign-extend, LBU/LHU zero-extend) and drives load_data. The core writes back and advances PC at the end of this cycle. Next state is IDLE.
- In RESP, inputs are ignored; the same instruction is still presented.
- A store followed by a load to the same address returns the new data. The write lands before the read is issued.

## Timing
- Reset values:
  - state: IDLE;
  - stall: 0;
  - fault and fault_sticky: 0;
  - load_data: 0;
  - latched offset and funct3: 0.
- RAM contents are not cleared by reset.
- Load latency is 2 cycles from presentation to write-back: stall for 1 cycle, then data valid.
- Store latency is 1 cycle.
- If reset is asserted during RESP, the unit returns to IDLE immediately, load_data becomes 0, and the load is abandoned.
- Back-to-back loads alternate IDLE/RESP, giving 2 cycles per load with no bubble beyond the stall.

## Structure
- Shared package riscv_mem_pkg holds:
  - funct3 constants (F3_LB … F3_SW);
  - the state enum {IDLE, RESP};
  - the lane-extract function.
- One sub-module, dmem_sram: DEPTH_WORDS×32 synchronous RAM with 4 byte enables and a registered read port.
- The FSM, fault decode, byte-enable generation and the extract mux live in load_store_unit.

## Test plan
- SW 0xDEADBEEF to 0x10, then LW 0x10: stall high for 1 cycle, then load_data=0xDEADBEEF.
- With word 0x10 = 0xDEADBEEF:
  - LB 0x13 gives 0xFFFFFFDE;
  - LBU 0x13 gives 0x000000DE;
  - LH 0x12 gives 0xFFFFDEAD;
  - LHU 0x10 gives 0x0000BEEF.
- SB 0x5A to 0x11 over 0xDEADBEEF, then LW 0x10 gives 0xDEAD5AEF. A store directly followed by a load returns the new value.
- LW 0x02, SH 0x01, funct3=011 load, and mem_read&mem_write each give:
  - a fault pulse and no stall;
  - load_data=0 and RAM unchanged;
  - fault_sticky=1 until reset.
- With DEPTH_WORDS=256, SW to 0x400 then LW 0x0 returns the stored data (wrap-around).
- Assert reset during RESP of a load: stall=0, load_data=0, state IDLE next cycle. The following LW behaves normally.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the RV32 data-memory stage: funct3 codes, load FSM
// states and the load-lane extract/extend helper.
package riscv_mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } lsu_state_e;

  // Select the addressed lane of a RAM word and sign/zero-extend it.
  function automatic logic [31:0] extract_lane(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input logic [2:0]  f3);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_LB:   r = {{24{b[7]}}, b};
      F3_LH:   r = {{16{h[15]}}, h};
      F3_LW:   r = word;
      F3_LBU:  r = {24'h000000, b};
      F3_LHU:  r = {16'h0000, h};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_sram.sv
// Single-port data RAM, DEPTH_WORDS x 32, per-byte write enables and a
// registered read port (one-cycle read latency). Contents are not reset.
module dmem_sram #(
  parameter int unsigned DEPTH_WORDS = 256
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [3:0]                     be,
  input  logic                           re,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [31:0]                    wdata,
  output logic [31:0]                    rdata
);

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/load_store_unit.sv
// Data-memory stage of the single-cycle RV32 core: fault decode, store lane
// steering, and a two-state load FSM that stalls one cycle per load.
module load_store_unit
  import riscv_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic        stall,
  output logic        fault,
  output logic        fault_sticky
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  lsu_state_e  state_q, state_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  f3_q, f3_d;
  logic        fault_sticky_q, fault_sticky_d;

  logic        illegal_f3;
  logic        misaligned;
  logic        access_fault;
  logic        ram_we, ram_re;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  logic        unused_addr;
  assign unused_addr = ^addr[31:AW+2];

  always_comb begin
    illegal_f3 = 1'b0;
    if (mem_read && !(funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU}))
      illegal_f3 = 1'b1;
    if (mem_write && !(funct3 inside {F3_SB, F3_SH, F3_SW}))
      illegal_f3 = 1'b1;

    // funct3[1:0] encodes the access size for every legal load and store
    case (funct3[1:0])
      2'b01:   misaligned = addr[0];
      2'b10:   misaligned = (addr[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase

    access_fault = (mem_read && mem_write)
                 || ((mem_read || mem_write) && (illegal_f3 || misaligned));
  end

  always_comb begin
    case (funct3)
      F3_SB: begin
        ram_be    = 4'b0001 << addr[1:0];
        ram_wdata = {4{store_data[7:0]}};
      end
      F3_SH: begin
        ram_be    = 4'b0011 << addr[1:0];
        ram_wdata = {2{store_data[15:0]}};
      end
      default: begin
        ram_be    = 4'b1111;
        ram_wdata = store_data;
      end
    endcase
  end

  // Outputs are forced quiet while reset is held so an abandoned load
  // cannot re-issue from IDLE with the same instruction still presented.
  always_comb begin
    state_d   = state_q;
    off_d     = off_q;
    f3_d      = f3_q;
    stall     = 1'b0;
    fault     = 1'b0;
    ram_re    = 1'b0;
    ram_we    = 1'b0;
    load_data = '0;

    case (state_q)
      IDLE: begin
        if (!reset) begin
          fault = access_fault;
          if (mem_read && !access_fault) begin
            stall   = 1'b1;
            ram_re  = 1'b1;
            off_d   = addr[1:0];
            f3_d    = funct3;
            state_d = RESP;
          end
          if (mem_write && !access_fault) ram_we = 1'b1;
        end
      end
      RESP: begin
        load_data = extract_lane(ram_rdata, off_q, f3_q);
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    fault_sticky_d = fault_sticky_q | fault;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      off_q          <= '0;
      f3_q           <= '0;
      fault_sticky_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      off_q          <= off_d;
      f3_q           <= f3_d;
      fault_sticky_q <= fault_sticky_d;
    end
  end

  assign fault_sticky = fault_sticky_q;

  dmem_sram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_dmem (
    .clk  (clk),
    .we   (ram_we),
    .be   (ram_be),
    .re   (ram_re),
    .addr (addr[AW+1:2]),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

endmodule
